// File: rtl/ring_counter_sequencer_pkg.sv
// ring_counter_sequencer_pkg
//   Definitions shared by the T-state ring counter and the controller
//   sequencer that decodes its output.
//   Contents:
//     seq_state_e       - sequencer FSM state encoding (RUN, STEP_WAIT, HALTED)
//     SHORT_LEN_DEFAULT - T-states in a 1-byte instruction
//     LONG_LEN_DEFAULT  - T-states in a 2-byte instruction
//     T0..T7            - T-state indices. The controller decodes its control
//                         words from these same positions.
package ring_counter_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STEP_WAIT = 2'd1,
        ST_HALTED    = 2'd2
    } seq_state_e;

    localparam int SHORT_LEN_DEFAULT = 6;
    localparam int LONG_LEN_DEFAULT  = 8;

    localparam logic [3:0] T0 = 4'd0;
    localparam logic [3:0] T1 = 4'd1;
    localparam logic [3:0] T2 = 4'd2;
    localparam logic [3:0] T3 = 4'd3;
    localparam logic [3:0] T4 = 4'd4;
    localparam logic [3:0] T5 = 4'd5;
    localparam logic [3:0] T6 = 4'd6;
    localparam logic [3:0] T7 = 4'd7;

endpackage

// File: rtl/ring_counter_sequencer_step_edge_detect.sv
// ring_counter_sequencer_step_edge_detect
//   Rising-edge detector for the single-step request. The previous sample of
//   req_i is held in a register, and rise_o is high in the cycle where req_i
//   is 1 and that previous sample was 0. Holding req_i high gives a single
//   pulse, so one press of the step input produces one advance.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset; clears the stored sample
//     req_i  in  step request, already synchronous to clk
//     rise_o out high for the cycle in which req_i goes from 0 to 1
module ring_counter_sequencer_step_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic rise_o
);

    logic req_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= req_i;
        end
    end

    assign rise_o = req_i & ~req_prev_q;

endmodule

// File: rtl/ring_counter_sequencer.sv
// ring_counter_sequencer
//   Generates the one-hot T-state vector for the controller sequencer. The
//   ring advances one T-state per advance event. An instruction ends after
//   SHORT_LEN T-states, or after LONG_LEN T-states when extended_fetch is
//   high at T(SHORT_LEN-1). The ring freezes to all-zero on hlt_clk. The
//   step_mode and step_req inputs give single-step operation.
//   Ports:
//     clk            in  system clock
//     rst_n          in  asynchronous active-low reset
//     extended_fetch in  1 = current instruction is 2-byte. Sampled at T5 only.
//     hlt_clk        in  halt request (ignored while halted)
//     resume         in  leave HALTED, back to T0
//     step_mode      in  1 = advance only on rising edges of step_req
//     step_req       in  single-step request
//     ring_counter   out one-hot T-state; zero while halted
//     t_state        out binary index of the active T-state
//     instr_done     out one-cycle pulse when the ring wraps to T0
//     halted         out 1 while in HALTED
//     instr_count    out retired-instruction count (wraps silently)
//     dbg_state      out current FSM state (seq_state_e encoding)
module ring_counter_sequencer
    import ring_counter_sequencer_pkg::*;
#(
    parameter int RING_W    = 10,
    parameter int SHORT_LEN = SHORT_LEN_DEFAULT,
    parameter int LONG_LEN  = LONG_LEN_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              extended_fetch,
    input  logic              hlt_clk,
    input  logic              resume,
    input  logic              step_mode,
    input  logic              step_req,
    output logic [RING_W-1:0] ring_counter,
    output logic [3:0]        t_state,
    output logic              instr_done,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count,
    output logic [1:0]        dbg_state
);

    localparam logic [3:0]        LAST_SHORT = 4'(SHORT_LEN - 1);
    localparam logic [3:0]        LAST_LONG  = 4'(LONG_LEN - 1);
    localparam logic [RING_W-1:0] RING_ONE   = {{(RING_W-1){1'b0}}, 1'b1};

    seq_state_e        state_q, state_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic [3:0]        t_q, t_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              step_rise;
    logic              advance;
    logic              wrap;
    logic [3:0]        t_next;

    ring_counter_sequencer_step_edge_detect u_step_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (step_req),
        .rise_o (step_rise)
    );

    // Compute the advance condition and the index that an advance would
    // produce. In RUN with step_mode=0 the ring free-runs. In every other
    // state it advances only on a step_req rising edge. This includes the
    // RUN cycle in which step_mode has just gone high. HALTED never advances.
    always_comb begin
        advance = ((state_q == ST_RUN) && !step_mode) ||
                  ((state_q != ST_HALTED) && step_rise);
        wrap    = 1'b0;
        t_next  = t_q + 4'd1;
        if (t_q == LAST_SHORT) begin
            // extended_fetch is sampled only here. At 1 the ring continues
            // into the 2-byte tail (T6, T7).
            if (!extended_fetch) begin
                wrap   = 1'b1;
                t_next = T0;
            end
        end else if (t_q == LAST_LONG) begin
            wrap   = 1'b1;
            t_next = T0;
        end
    end

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        t_d     = t_q;
        done_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_HALTED: begin
                // hlt_clk is ignored here, so resume wins when both are high.
                if (resume) begin
                    state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
                    t_d     = T0;
                    ring_d  = RING_ONE;
                end
            end
            default: begin
                if (hlt_clk) begin
                    // Halt takes priority over any advance in the same cycle.
                    // The partial HLT instruction does not count as retired.
                    state_d = ST_HALTED;
                    t_d     = T0;
                    ring_d  = '0;
                end else begin
                    state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
                    if (advance) begin
                        t_d    = t_next;
                        ring_d = RING_ONE << t_next;
                        if (wrap) begin
                            done_d  = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ring_q  <= RING_ONE;
            t_q     <= T0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            t_q     <= t_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign ring_counter = ring_q;
    assign t_state      = t_q;
    assign instr_done   = done_q;
    assign halted       = (state_q == ST_HALTED);
    assign instr_count  = count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ring_counter_sequencer.sv
module tb_ring_counter_sequencer;
  import ring_counter_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic extended_fetch = 1'b0;
  logic hlt_clk = 1'b0;
  logic resume = 1'b0;
  logic step_mode = 1'b0;
  logic step_req = 1'b0;

  logic [9:0]  ring_counter;
  logic [3:0]  t_state;
  logic        instr_done;
  logic        halted;
  logic [15:0] instr_count;
  logic [1:0]  dbg_state;

  // Second instance with a 4-bit counter, so the count wrap can be reached
  // in a short run.
  logic [9:0]  s_ring;
  logic [3:0]  s_t;
  logic        s_done;
  logic        s_halted;
  logic [3:0]  s_count;
  logic [1:0]  s_state;

  ring_counter_sequencer #(.RING_W(10), .SHORT_LEN(6), .LONG_LEN(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .extended_fetch(extended_fetch), .hlt_clk(hlt_clk),
    .resume(resume), .step_mode(step_mode), .step_req(step_req),
    .ring_counter(ring_counter), .t_state(t_state), .instr_done(instr_done),
    .halted(halted), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  ring_counter_sequencer #(.RING_W(10), .SHORT_LEN(6), .LONG_LEN(8), .CNT_W(4)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .extended_fetch(extended_fetch), .hlt_clk(hlt_clk),
    .resume(resume), .step_mode(step_mode), .step_req(step_req),
    .ring_counter(s_ring), .t_state(s_t), .instr_done(s_done),
    .halted(s_halted), .instr_count(s_count), .dbg_state(s_state)
  );

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [9:0] ring, input logic [3:0] t,
                           input logic done, input logic hlt, input logic [15:0] cnt,
                           input logic [1:0] st);
    check({tag, ".ring"}, 32'(ring_counter), 32'(ring));
    check({tag, ".t_state"}, 32'(t_state), 32'(t));
    check({tag, ".instr_done"}, 32'(instr_done), 32'(done));
    check({tag, ".halted"}, 32'(halted), 32'(hlt));
    check({tag, ".instr_count"}, 32'(instr_count), 32'(cnt));
    check({tag, ".state"}, 32'(dbg_state), 32'(st));
  endtask

  // One-hot invariant, checked on every falling edge once the bench is running.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      total++;
      if (halted ? (ring_counter != 10'd0)
                 : (!$onehot(ring_counter) || ring_counter != (10'd1 << t_state))) begin
        bad++;
        $display("FAIL onehot ring=%0h t=%0d halted=%0b at %0t", ring_counter, t_state, halted, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    extended_fetch = 1'b0; hlt_clk = 1'b0; resume = 1'b0;
    step_mode = 1'b0; step_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ext, hlt, res, sm, sr;
    logic [9:0] ring;
    logic [3:0] t;
    logic       done, hl;
    logic [15:0] cnt;
    logic [1:0] st;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ext, input logic hlt, input logic res, input logic sm,
                     input logic sr, input logic [9:0] ring, input logic [3:0] t,
                     input logic done, input logic hl, input logic [15:0] cnt,
                     input logic [1:0] st);
    vec_t v;
    v.ext = ext; v.hlt = hlt; v.res = res; v.sm = sm; v.sr = sr;
    v.ring = ring; v.t = t; v.done = done; v.hl = hl; v.cnt = cnt; v.st = st;
    vq.push_back(v);
  endtask

  initial begin
    // Two 1-byte instructions: ring 002..020 then back to 001, done at cycles 6 and 12.
    //   ext hlt res sm sr  ring     t  done hl cnt st
    add(0, 0, 0, 0, 0, 10'h002, 1, 0, 0, 0, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h004, 2, 0, 0, 0, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h008, 3, 0, 0, 0, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h010, 4, 0, 0, 0, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h020, 5, 0, 0, 0, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h001, 0, 1, 0, 1, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h002, 1, 0, 0, 1, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h004, 2, 0, 0, 1, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h008, 3, 0, 0, 1, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h010, 4, 0, 0, 1, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h020, 5, 0, 0, 1, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h001, 0, 1, 0, 2, ST_RUN);
    // 2-byte instruction: ext=1 at T5 goes on to T6, T7, then wraps.
    // ext=1 outside T5 is ignored.
    add(1, 0, 0, 0, 0, 10'h002, 1, 0, 0, 2, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h004, 2, 0, 0, 2, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h008, 3, 0, 0, 2, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h010, 4, 0, 0, 2, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h020, 5, 0, 0, 2, ST_RUN);
    add(1, 0, 0, 0, 0, 10'h040, 6, 0, 0, 2, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h080, 7, 0, 0, 2, ST_RUN);
    add(1, 0, 0, 0, 0, 10'h001, 0, 1, 0, 3, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h002, 1, 0, 0, 3, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h004, 2, 0, 0, 3, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h008, 3, 0, 0, 3, ST_RUN);
    // Halt at T3. The count is unchanged, and step_req/ext are ignored while halted.
    add(0, 1, 0, 0, 0, 10'h000, 0, 0, 1, 3, ST_HALTED);
    add(0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 3, ST_HALTED);
    add(1, 0, 0, 0, 1, 10'h000, 0, 0, 1, 3, ST_HALTED);
    add(0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 3, ST_HALTED);
    add(0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 3, ST_HALTED);
    // resume and hlt_clk together: resume wins.
    add(0, 1, 1, 0, 0, 10'h001, 0, 0, 0, 3, ST_RUN);
    add(0, 0, 0, 0, 0, 10'h002, 1, 0, 0, 3, ST_RUN);

    do_reset();
    mon_en = 1'b1;
    check_all("reset", 10'h001, 0, 0, 0, 0, ST_RUN);

    foreach (vq[i]) begin
      extended_fetch = vq[i].ext; hlt_clk = vq[i].hlt; resume = vq[i].res;
      step_mode = vq[i].sm; step_req = vq[i].sr;
      tick();
      check_all($sformatf("vec%0d", i), vq[i].ring, vq[i].t, vq[i].done, vq[i].hl,
                vq[i].cnt, vq[i].st);
    end

    // ---------------- step mode ----------------
    do_reset();
    step_mode = 1'b1;
    tick();
    check_all("step_enter", 10'h001, 0, 0, 0, 0, ST_STEP_WAIT);
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1; tick();
      step_req = 1'b0; tick();
    end
    check_all("step_3pulses", 10'h008, 3, 0, 0, 0, ST_STEP_WAIT);
    step_req = 1'b1;
    tick();
    check_all("step_hold1", 10'h010, 4, 0, 0, 0, ST_STEP_WAIT);
    repeat (3) tick();
    check_all("step_hold4", 10'h010, 4, 0, 0, 0, ST_STEP_WAIT);
    step_req = 1'b0;
    tick();
    check_all("step_release", 10'h010, 4, 0, 0, 0, ST_STEP_WAIT);

    // hlt_clk together with a step rising edge: halt, no advance.
    step_req = 1'b1; hlt_clk = 1'b1;
    tick();
    check_all("halt_vs_step", 10'h000, 0, 0, 1, 0, ST_HALTED);
    step_req = 1'b0; hlt_clk = 1'b0;
    tick();
    resume = 1'b1;
    tick();
    check_all("resume_step", 10'h001, 0, 0, 0, 0, ST_STEP_WAIT);
    resume = 1'b0; step_mode = 1'b0;
    tick();
    check_all("mode_change", 10'h001, 0, 0, 0, 0, ST_RUN);
    tick();
    check_all("run_again", 10'h002, 1, 0, 0, 0, ST_RUN);

    // ---------------- async reset mid-T6 ----------------
    do_reset();
    repeat (11) tick();
    check_all("pre_t5", 10'h020, 5, 0, 0, 1, ST_RUN);
    extended_fetch = 1'b1;
    tick();
    extended_fetch = 1'b0;
    check_all("at_t6", 10'h040, 6, 0, 0, 1, ST_RUN);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 10'h001, 0, 0, 0, 0, ST_RUN);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- counter wrap (CNT_W=4 instance) ----------------
    do_reset();
    repeat (90) tick();
    check("small_count15", 32'(s_count), 32'd15);
    repeat (6) tick();
    check("small_count_wrap", 32'(s_count), 32'd0);
    check("small_done_wrap", 32'(s_done), 32'd1);
    check("big_count16", 32'(instr_count), 32'd16);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
